// File: rtl/shift_tx_ctrl_if.sv
// Word handshake between a producer and shift_tx_ctrl.
// The master is the word producer and the slave is the controller.
interface shift_tx_ctrl_if #(
  parameter int SHIFT_WIDTH = 8
) ();
  logic [SHIFT_WIDTH-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/shift_tx_ctrl.sv
// shift_tx_ctrl: sequences a left-shifting `sr` instance to serialise each
// accepted word MSB-first, one shift every BIT_DIV clocks, then holds off
// new words for GAP_CYCLES idle clocks.
// Optional feature macro: SHIFT_TX_CTRL_PARITY_EN. When it is defined, an even
// parity bit is fed into shiftin on the first shift and leaves the register
// as bit NB = SHIFT_WIDTH+1.
module shift_tx_ctrl #(
  parameter int SHIFT_WIDTH = 8,
  parameter int BIT_DIV     = 4,
  parameter int GAP_CYCLES  = 2,
`ifdef SHIFT_TX_CTRL_PARITY_EN
  localparam int NB = SHIFT_WIDTH + 1,
`else
  localparam int NB = SHIFT_WIDTH,
`endif
  localparam int CW = $clog2(NB + 1)
) (
  input  logic                   clock,
  input  logic                   sclr,
  shift_tx_ctrl_if.slave         in_if,
  output logic                   sr_sclr,
  output logic                   sr_load,
  output logic                   sr_enable,
  output logic [SHIFT_WIDTH-1:0] sr_data,
  output logic                   sr_shiftin,
  output logic                   bit_strobe,
  output logic [CW-1:0]          bit_cnt,
  output logic                   done,
  output logic                   busy
);

  localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] NB_C     = CW'(NB);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t                 state_r, state_s;
  logic [DW-1:0]          div_r, div_s;
  logic [CW-1:0]          shift_cnt_r, shift_cnt_s;
  logic [GW-1:0]          gap_cnt_r, gap_cnt_s;
  logic                   sr_sclr_r;
  logic                   sr_load_r, sr_load_s;
  logic                   sr_enable_r, sr_enable_s;
  logic [SHIFT_WIDTH-1:0] sr_data_r, sr_data_s;
  logic                   bit_strobe_r, bit_strobe_s;
  logic [CW-1:0]          bit_cnt_r, bit_cnt_s;
  logic                   done_r, done_s;
  logic                   busy_r, busy_s;
  logic                   handshake_s;
  logic                   shift_now_s;

`ifdef SHIFT_TX_CTRL_PARITY_EN
  logic parity_r, parity_s;
  logic sr_shiftin_r, sr_shiftin_s;

  function automatic logic even_parity(input logic [SHIFT_WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  assign handshake_s = in_if.in_valid & ~busy_r;
  // A shift cycle is one in which the registered enable is high outside LOAD.
  assign shift_now_s = (state_r == ST_SHIFT) & sr_enable_r;

  // Next-state, counter and next-output decode for the frame sequencer
  always_comb begin
    state_s      = state_r;
    div_s        = div_r;
    shift_cnt_s  = shift_cnt_r;
    gap_cnt_s    = gap_cnt_r;
    sr_data_s    = sr_data_r;
    bit_strobe_s = 1'b0;
    bit_cnt_s    = {CW{1'b0}};
    done_s       = 1'b0;
`ifdef SHIFT_TX_CTRL_PARITY_EN
    parity_s     = parity_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (handshake_s) begin
          state_s     = ST_LOAD;
          sr_data_s   = in_if.in_data;
          div_s       = {DW{1'b0}};
          shift_cnt_s = {CW{1'b0}};
          gap_cnt_s   = {GW{1'b0}};
`ifdef SHIFT_TX_CTRL_PARITY_EN
          parity_s    = even_parity(in_if.in_data);
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_s     = ST_SHIFT;
        div_s       = {DW{1'b0}};
        shift_cnt_s = {CW{1'b0}};
      end
      ST_SHIFT: begin
        div_s = (div_r == DIV_LAST) ? {DW{1'b0}} : div_r + DW'(1);
        if (shift_now_s) begin
          shift_cnt_s  = shift_cnt_r + CW'(1);
          bit_strobe_s = 1'b1;
          bit_cnt_s    = shift_cnt_r + CW'(1);
          done_s       = ((shift_cnt_r + CW'(1)) == NB_C);
        end else begin
          shift_cnt_s = shift_cnt_r;
        end
        // The frame ends once the cycle carrying the last bit has gone by.
        if (done_r) begin
          gap_cnt_s = {GW{1'b0}};
          state_s   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_s = ST_IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r + GW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from next-cycle values.
    sr_load_s   = (state_s == ST_LOAD);
    sr_enable_s = sr_load_s |
                  ((state_s == ST_SHIFT) & (div_s == DIV_LAST) & (shift_cnt_s < NB_C));
    busy_s      = (state_s != ST_IDLE);
`ifdef SHIFT_TX_CTRL_PARITY_EN
    // Parity enters the register on the first shift only.
    sr_shiftin_s = parity_s & (state_s == ST_SHIFT) & sr_enable_s &
                   (shift_cnt_s == {CW{1'b0}});
`endif
  end

  // Sequencer state and registered outputs; sclr abandons any frame
  always_ff @(posedge clock) begin
    if (sclr) begin
      state_r      <= ST_IDLE;
      div_r        <= {DW{1'b0}};
      shift_cnt_r  <= {CW{1'b0}};
      gap_cnt_r    <= {GW{1'b0}};
      sr_load_r    <= 1'b0;
      sr_enable_r  <= 1'b0;
      sr_data_r    <= {SHIFT_WIDTH{1'b0}};
      bit_strobe_r <= 1'b0;
      bit_cnt_r    <= {CW{1'b0}};
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
`ifdef SHIFT_TX_CTRL_PARITY_EN
      parity_r     <= 1'b0;
      sr_shiftin_r <= 1'b0;
`endif
    end else begin
      state_r      <= state_s;
      div_r        <= div_s;
      shift_cnt_r  <= shift_cnt_s;
      gap_cnt_r    <= gap_cnt_s;
      sr_load_r    <= sr_load_s;
      sr_enable_r  <= sr_enable_s;
      sr_data_r    <= sr_data_s;
      bit_strobe_r <= bit_strobe_s;
      bit_cnt_r    <= bit_cnt_s;
      done_r       <= done_s;
      busy_r       <= busy_s;
`ifdef SHIFT_TX_CTRL_PARITY_EN
      parity_r     <= parity_s;
      sr_shiftin_r <= sr_shiftin_s;
`endif
    end
  end

  // Delayed copy of sclr so the shift register clears one cycle later
  always_ff @(posedge clock) begin
    sr_sclr_r <= sclr;
  end

  assign in_if.in_ready = ~busy_r;
  assign sr_sclr        = sr_sclr_r;
  assign sr_load        = sr_load_r;
  assign sr_enable      = sr_enable_r;
  assign sr_data        = sr_data_r;
  assign bit_strobe     = bit_strobe_r;
  assign bit_cnt        = bit_cnt_r;
  assign done           = done_r;
  assign busy           = busy_r;
`ifdef SHIFT_TX_CTRL_PARITY_EN
  assign sr_shiftin     = sr_shiftin_r;
`else
  assign sr_shiftin     = 1'b0;
`endif

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Scoreboard bench for shift_tx_ctrl: two controller instances (8/4/2 and
// 8/1/0) each drive a behavioural left-shift register; a monitor compares
// every strobe against expectations queued at the handshake.
module tb_shift_tx_ctrl;

  localparam int W     = 8;
  localparam int A_DIV = 4;
  localparam int A_GAP = 2;
  localparam int B_DIV = 1;
  localparam int B_GAP = 0;
`ifdef SHIFT_TX_CTRL_PARITY_EN
  localparam int NBT = W + 1;
`else
  localparam int NBT = W;
`endif

  typedef struct {
    int   cyc;
    logic b;
    int   cnt;
    logic d;
  } exp_t;

  logic clock;
  logic sclr;
  int   cyc;
  int   total;
  int   bad;

  shift_tx_ctrl_if #(.SHIFT_WIDTH(W)) ifa ();
  shift_tx_ctrl_if #(.SHIFT_WIDTH(W)) ifb ();

  logic         a_sr_sclr, a_sr_load, a_sr_enable, a_sr_shiftin, a_strobe, a_done, a_busy;
  logic [W-1:0] a_sr_data;
  logic [3:0]   a_cnt;
  logic         b_sr_sclr, b_sr_load, b_sr_enable, b_sr_shiftin, b_strobe, b_done, b_busy;
  logic [W-1:0] b_sr_data;
  logic [3:0]   b_cnt;

  shift_tx_ctrl #(.SHIFT_WIDTH(W), .BIT_DIV(A_DIV), .GAP_CYCLES(A_GAP)) dut_a (
    .clock(clock), .sclr(sclr), .in_if(ifa),
    .sr_sclr(a_sr_sclr), .sr_load(a_sr_load), .sr_enable(a_sr_enable),
    .sr_data(a_sr_data), .sr_shiftin(a_sr_shiftin), .bit_strobe(a_strobe),
    .bit_cnt(a_cnt), .done(a_done), .busy(a_busy)
  );

  shift_tx_ctrl #(.SHIFT_WIDTH(W), .BIT_DIV(B_DIV), .GAP_CYCLES(B_GAP)) dut_b (
    .clock(clock), .sclr(sclr), .in_if(ifb),
    .sr_sclr(b_sr_sclr), .sr_load(b_sr_load), .sr_enable(b_sr_enable),
    .sr_data(b_sr_data), .sr_shiftin(b_sr_shiftin), .bit_strobe(b_strobe),
    .bit_cnt(b_cnt), .done(b_done), .busy(b_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural `sr` models: left shift, registered shiftout, load has priority.
  logic [W-1:0] a_reg, b_reg;
  logic         a_so, b_so;
  always @(posedge clock) begin
    if (a_sr_sclr) begin a_reg <= '0; a_so <= 1'b0; end
    else if (a_sr_load) a_reg <= a_sr_data;
    else if (a_sr_enable) begin a_so <= a_reg[W-1]; a_reg <= {a_reg[W-2:0], a_sr_shiftin}; end
  end
  always @(posedge clock) begin
    if (b_sr_sclr) begin b_reg <= '0; b_so <= 1'b0; end
    else if (b_sr_load) b_reg <= b_sr_data;
    else if (b_sr_enable) begin b_so <= b_reg[W-1]; b_reg <= {b_reg[W-2:0], b_sr_shiftin}; end
  end

  exp_t         a_sb[$], b_sb[$];
  logic [W-1:0] a_acc[$], b_acc[$];
  int a_load_exp = -1, b_load_exp = -1;
  int a_rdy_exp = -1, b_rdy_exp = -1;
  logic [W-1:0] a_word_exp, b_word_exp;
  logic a_rdy_prev = 1'b0, b_rdy_prev = 1'b0;
  int a_bits = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic exp_bit(input logic [W-1:0] w, input int k);
    if (k <= W) return w[W-k];
    else return ^w;
  endfunction

  // Monitor for instance A: load cycle, every strobe, ready return; queue on handshake.
  always @(negedge clock) begin
    exp_t e;
    if (a_sr_load === 1'b1) begin
      check("a_load_cyc", cyc, a_load_exp);
      check("a_load_ctl", {a_sr_enable, a_busy, a_sr_data}, {1'b1, 1'b1, a_word_exp});
    end
    if (a_strobe === 1'b1) begin
      if (a_sb.size() == 0) begin
        check("a_unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = a_sb.pop_front();
        check("a_bit_cyc", cyc, e.cyc);
        check("a_bit_val", {a_so, a_cnt, a_done}, {e.b, e.cnt[3:0], e.d});
        a_bits++;
      end
    end else if (a_done === 1'b1) begin
      check("a_done_no_strobe", 32'd1, 32'd0);
    end
    if (ifa.in_ready && !a_rdy_prev && a_rdy_exp >= 0) check("a_ready_cyc", cyc, a_rdy_exp);
    a_rdy_prev = ifa.in_ready;
    if (ifa.in_valid && ifa.in_ready && !sclr) begin
      a_acc.push_back(ifa.in_data);
      a_load_exp = cyc + 1;
      a_word_exp = ifa.in_data;
      a_rdy_exp  = cyc + 3 + A_DIV * NBT + A_GAP;
      for (int k = 1; k <= NBT; k++) begin
        e.cyc = cyc + 2 + A_DIV * k;
        e.b   = exp_bit(ifa.in_data, k);
        e.cnt = k;
        e.d   = (k == NBT);
        a_sb.push_back(e);
      end
    end
  end

  // Monitor for instance B, same checks with its own divider and gap.
  always @(negedge clock) begin
    exp_t e;
    if (b_sr_load === 1'b1) begin
      check("b_load_cyc", cyc, b_load_exp);
      check("b_load_ctl", {b_sr_enable, b_busy, b_sr_data}, {1'b1, 1'b1, b_word_exp});
    end
    if (b_strobe === 1'b1) begin
      if (b_sb.size() == 0) begin
        check("b_unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = b_sb.pop_front();
        check("b_bit_cyc", cyc, e.cyc);
        check("b_bit_val", {b_so, b_cnt, b_done}, {e.b, e.cnt[3:0], e.d});
      end
    end else if (b_done === 1'b1) begin
      check("b_done_no_strobe", 32'd1, 32'd0);
    end
    if (ifb.in_ready && !b_rdy_prev && b_rdy_exp >= 0) check("b_ready_cyc", cyc, b_rdy_exp);
    b_rdy_prev = ifb.in_ready;
    if (ifb.in_valid && ifb.in_ready && !sclr) begin
      b_acc.push_back(ifb.in_data);
      b_load_exp = cyc + 1;
      b_word_exp = ifb.in_data;
      b_rdy_exp  = cyc + 3 + B_DIV * NBT + B_GAP;
      for (int k = 1; k <= NBT; k++) begin
        e.cyc = cyc + 2 + B_DIV * k;
        e.b   = exp_bit(ifb.in_data, k);
        e.cnt = k;
        e.d   = (k == NBT);
        b_sb.push_back(e);
      end
    end
  end

  // Present a word and wait (bounded) until the handshake edge is next.
  task automatic send(input int sel, input logic [W-1:0] w, input logic keep);
    logic ok;
    ok = 1'b0;
    @(posedge clock); #1;
    if (sel == 0) begin ifa.in_data = w; ifa.in_valid = 1'b1; end
    else begin ifb.in_data = w; ifb.in_valid = 1'b1; end
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if ((sel == 0 && ifa.in_ready) || (sel != 0 && ifb.in_ready)) begin ok = 1'b1; break; end
    end
    check("handshake_timeout", {31'd0, ok}, 32'd1);
    if (!keep) begin
      @(posedge clock); #1;
      if (sel == 0) ifa.in_valid = 1'b0; else ifb.in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int sel);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (sel == 0 && a_sb.size() == 0 && ifa.in_ready) begin ok = 1'b1; break; end
      if (sel != 0 && b_sb.size() == 0 && ifb.in_ready) begin ok = 1'b1; break; end
    end
    check("idle_timeout", {31'd0, ok}, 32'd1);
  endtask

  logic [W-1:0] a_words [8] = '{8'hA5, 8'h3C, 8'hC3, 8'hA5, 8'hFF, 8'h5A, 8'h07, 8'h03};
  logic [W-1:0] b_words [2] = '{8'h81, 8'h3C};

  initial begin
    logic ok;
    total = 0; bad = 0; cyc = 0;
    sclr = 1'b1;
    ifa.in_valid = 1'b0; ifa.in_data = '0;
    ifb.in_valid = 1'b0; ifb.in_data = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("a_reset", {a_sr_load, a_sr_enable, a_sr_data, a_sr_shiftin, a_strobe, a_cnt, a_done, a_busy, ifa.in_ready, a_sr_sclr},
          {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1});
    check("b_reset", {b_sr_load, b_sr_enable, b_sr_data, b_sr_shiftin, b_strobe, b_cnt, b_done, b_busy, ifb.in_ready, b_sr_sclr},
          {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1});
    @(posedge clock); #1 sclr = 1'b0;

    // Basic frame, back-to-back pair, busy-ignore.
    send(0, 8'hA5, 1'b0); wait_idle(0);
    send(0, 8'h3C, 1'b1); send(0, 8'hC3, 1'b0); wait_idle(0);
    send(0, 8'hA5, 1'b0);
    repeat (10) @(posedge clock);
    #1 ifa.in_data = 8'h55; ifa.in_valid = 1'b1;
    @(negedge clock);
    check("busy_ready_low", {31'd0, ifa.in_ready}, 32'd0);
    @(posedge clock); #1 ifa.in_valid = 1'b0;
    wait_idle(0);

    // Mid-frame sclr after bit 3 of 0xFF, then an immediate new word.
    a_bits = 0;
    send(0, 8'hFF, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (a_bits >= 3) begin ok = 1'b1; break; end
    end
    check("bit3_timeout", {31'd0, ok}, 32'd1);
    @(posedge clock); #1;
    sclr = 1'b1; a_sb.delete(); a_rdy_exp = -1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      if (i == 2) begin sclr = 1'b0; ifa.in_data = 8'h5A; ifa.in_valid = 1'b1; end
      @(negedge clock);
      check("sclr_state", {a_busy, ifa.in_ready, a_sr_sclr, a_done, a_strobe}, {1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      if (i >= 1) check("sclr_sr_q", a_reg, 8'h00);
    end
    @(posedge clock); #1 ifa.in_valid = 1'b0;
    wait_idle(0);

    // Parity-relevant words (plain frames when parity is disabled).
    send(0, 8'h07, 1'b0); wait_idle(0);
    send(0, 8'h03, 1'b0); wait_idle(0);

    // Fast instance: BIT_DIV=1, GAP_CYCLES=0.
    send(1, 8'h81, 1'b0); wait_idle(1);
    send(1, 8'h3C, 1'b0); wait_idle(1);
    repeat (4) @(negedge clock);

    check("a_accept_count", a_acc.size(), 8);
    for (int i = 0; i < 8 && i < a_acc.size(); i++) check("a_accept_word", a_acc[i], a_words[i]);
    check("b_accept_count", b_acc.size(), 2);
    for (int i = 0; i < 2 && i < b_acc.size(); i++) check("b_accept_word", b_acc[i], b_words[i]);
    check("a_sb_empty", a_sb.size(), 0);
    check("b_sb_empty", b_sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/shift_tx_ctrl.md
# shift_tx_ctrl

Sequencing controller for the parameterised left-shifting shift register (`sr`) in the memory library. It accepts parallel words over a valid/ready handshake and drives the register's control ports to load and serialise each word MSB-first, one shift every BIT_DIV clocks. It reports every valid serial bit and the end of each frame, and enforces an idle gap between frames. It sits between a word producer and one `sr` instance configured with SHIFT_DIRECTION "LEFT"; the serial bit is taken from that instance's `shiftout`.

## Interface
- SHIFT_WIDTH, 8: word width; must equal the `sr` instance's SHIFT_WIDTH.
- BIT_DIV, 4: clocks per shift, ≥1.
- GAP_CYCLES, 2: idle clocks after the last bit, ≥0.

- clock  in  1  single clock, rising edge.
- sclr  in  1  reset; synchronous and active-high.
- in_data  in  SHIFT_WIDTH  word to transmit.
- in_valid  in  1  producer has a word.
- in_ready  out  1  combinational, equal to ~busy; transfer occurs when in_valid & in_ready at a rising edge.
- sr_sclr  out  1  registered copy of sclr, drives the `sr` sclr port.
- sr_load  out  1  drives `sr` load.
- sr_enable  out  1  drives `sr` enable.
- sr_data  out  SHIFT_WIDTH  drives `sr` data.
- sr_shiftin  out  1  drives `sr` shiftin.
- bit_strobe  out  1  `sr` shiftout holds a new valid bit this cycle.
- bit_cnt  out  clog2(NB+1)  index (1..NB) of the bit currently flagged.
- done  out  1  one-cycle pulse, coincident with the last bit_strobe of a frame.
- busy  out  1  frame in progress, including the gap.

## Operation
- NB = SHIFT_WIDTH, or SHIFT_WIDTH+1 when parity is enabled.
- States:
  - IDLE → LOAD on handshake; the word is captured into sr_data.
  - LOAD (1 cycle) → SHIFT.
  - SHIFT → GAP after the NB-th shift, or → IDLE directly if GAP_CYCLES=0.
  - GAP → IDLE after GAP_CYCLES cycles.
- LOAD drives sr_load=1 and sr_enable=1.
- In SHIFT, a divider counts BIT_DIV clocks. At terminal count the controller drives sr_enable=1, sr_load=0 for exactly one cycle. At all other times sr_enable=0.
- sr_shiftin is 0 unless parity is enabled.
- sr_data holds the captured word from LOAD until the next handshake.
- in_valid while busy is ignored; nothing is buffered.
- sclr is synchronous and has priority over everything else:
  - state goes to IDLE;
  - all counters clear;
  - the frame is abandoned with no done pulse;
  - sr_sclr asserts on the following cycle so the `sr` instance also clears.
- Reset values (cycle after an sclr edge): sr_load=0, sr_enable=0, sr_data=0, sr_shiftin=0, bit_strobe=0, bit_cnt=0, done=0, busy=0, in_ready=1, sr_sclr=1 (while sclr held).

## Timing
Cycle N is the handshake edge.
- N+1: sr_load=sr_enable=1, busy=1.
- Shift k (k=1..NB): sr_enable=1 in cycle N+1+BIT_DIV·k.
- Bit k: bit_strobe=1 and bit_cnt=k in cycle N+2+BIT_DIV·k; `sr` shiftout carries data bit SHIFT_WIDTH−k.
- Frame end: done=1 in cycle N+2+BIT_DIV·NB.
- busy deasserts, and in_ready asserts, in cycle N+3+BIT_DIV·NB+GAP_CYCLES.
- The earliest next handshake is that cycle's edge.
- BIT_DIV=1: a shift occurs every cycle, back to back.
- All outputs except in_ready are registered.

## Configuration
- SHIFT_TX_CTRL_PARITY_EN defined:
  - NB = SHIFT_WIDTH+1.
  - At LOAD the controller computes even parity P = ^in_data.
  - It drives sr_shiftin=P during shift 1 and 0 during later shifts.
  - Shift NB therefore presents P on shiftout with bit_cnt=NB, and done coincides with it.
- Undefined: NB = SHIFT_WIDTH, sr_shiftin is tied 0, and there is no parity logic.

## Test plan
- Reset: hold sclr 3 cycles mid-frame (after bit 3 of 0xFF).
  - busy=0, in_ready=1, no done pulse.
  - sr_sclr high the cycle after each sclr cycle; `sr` q=0.
  - A new word is accepted on the next edge.
- Basic frame: 8/4/2, no parity, send 0xA5 at N.
  - bit_strobe at N+6, N+10, … N+34 with shiftout 1,0,1,0,0,1,0,1.
  - done at N+34; in_ready back at N+37.
- Back-to-back: 0x3C then 0xC3 with in_valid held high.
  - Second handshake at N+37; serial stream 00111100 11000011.
  - No missing or duplicate strobes.
- BIT_DIV=1, GAP_CYCLES=0: 0x81 at N.
  - Strobes N+3..N+10 with bits 1,0,0,0,0,0,0,1.
  - in_ready at N+11.
- Parity (SHIFT_TX_CTRL_PARITY_EN): 0x07 → 9th bit 1; 0x03 → 9th bit 0.
  - 9th bit at N+38 with bit_cnt=9 and done=1.
- Busy ignore: pulse in_valid with 0x55 during the SHIFT of 0xA5.
  - Transmitted stream is unchanged; 0x55 is never sent.
